// File: rtl/rv_mem_arbiter.sv
// Shares one Avalon-MM memory master between an instruction port and a data
// port. Priority alternates between the ports, and a stalled transfer is aborted.
module rv_mem_arbiter #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,

    input  logic [31:0] d_address,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    input  logic        d_read,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,

    output logic [31:0] m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,

    output logic [1:0]  grant,
    output logic        timeout_err,
    input  logic        err_clr
);

    // Handshake: a requester holds address/data/strobe until it sees its
    // waitrequest low; that single low cycle is the completion (or abort).
    // The state encoding equals the one-hot grant value, so grant exposes the FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } state_e;

    // The counter holds the stalls already finished, so the TIMEOUT-th stalled
    // cycle is the one in which the counter reads TIMEOUT-1.
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        last_gnt_d_q, last_gnt_d_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic        i_req;
    logic        d_req;
    logic        granted;
    logic        done;
    logic        abort;
    logic        xfer_end;

    always_comb begin
        i_req    = i_read;
        d_req    = d_read | d_write;
        granted  = (state_q != ST_IDLE);
        done     = granted & ~m_waitrequest;
        abort    = granted & m_waitrequest & (TIMEOUT != 0) & (wait_cnt_q == TO_LAST);
        xfer_end = done | abort;
    end

    always_comb begin
        state_d       = state_q;
        last_gnt_d_d  = last_gnt_d_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (i_req && d_req) begin
                    state_d = last_gnt_d_q ? ST_GNT_I : ST_GNT_D;
                end else if (i_req) begin
                    state_d = ST_GNT_I;
                end else if (d_req) begin
                    state_d = ST_GNT_D;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                // A dropped request does not release the grant; only completion or abort does.
                if (xfer_end) begin
                    state_d      = ST_IDLE;
                    last_gnt_d_d = (state_q == ST_GNT_D);
                    wait_cnt_d   = '0;
                end else if (wait_cnt_q != 16'hFFFF) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_gnt_d_q  <= 1'b1;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_gnt_d_q  <= last_gnt_d_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        m_address     = '0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        m_read        = 1'b0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = '0;
        d_readdata    = '0;

        unique case (state_q)
            ST_GNT_I: begin
                m_address    = i_address;
                m_read       = i_read;
                m_byteenable = 4'hF;
                if (xfer_end) begin
                    i_waitrequest = 1'b0;
                    i_readdata    = abort ? ERR_DATA : m_readdata;
                end
            end
            ST_GNT_D: begin
                // A simultaneous read and write request is served as the write.
                m_address    = d_address;
                m_write      = d_write;
                m_read       = d_read & ~d_write;
                m_writedata  = d_writedata;
                m_byteenable = d_byteenable;
                if (xfer_end) begin
                    d_waitrequest = 1'b0;
                    d_readdata    = abort ? ERR_DATA : m_readdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign grant       = state_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: directed scenarios with literal expectations, then
// random Avalon-style traffic checked every cycle against a behavioural model.
module tb_rv_mem_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] i_address;
    logic        i_read;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic [31:0] d_address;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_read;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic [1:0]  grant;
    logic        timeout_err;
    logic        err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    rv_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_readdata    (i_readdata),
        .i_waitrequest (i_waitrequest),
        .d_address     (d_address),
        .d_write       (d_write),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_read        (d_read),
        .d_readdata    (d_readdata),
        .d_waitrequest (d_waitrequest),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_read        (m_read),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .grant         (grant),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drain();
        tick();
        i_read        = 1'b0;
        d_read        = 1'b0;
        d_write       = 1'b0;
        m_waitrequest = 1'b0;
        err_clr       = 1'b0;
        tick();
        tick();
    endtask

    // Behavioural model: owner 0 = nobody, 1 = instruction, 2 = data.
    int owner = 0, last_owner = 2, stalls = 0;
    bit err = 1'b0;
    int owner_n = 0, last_n = 2, stalls_n = 0;
    bit err_n = 1'b0;
    logic seen_iw = 1'b1, seen_dw = 1'b1;

    always @(negedge clk) begin : model_cmp
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        logic [3:0]  e_be;
        logic        e_rd, e_wr, e_iw, e_dw;
        logic [1:0]  e_gnt;
        bit          fin, ab;

        e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0; e_be = '0;
        e_rd = 1'b0; e_wr = 1'b0; e_iw = 1'b1; e_dw = 1'b1; e_gnt = 2'b00;
        fin = (owner != 0) && !m_waitrequest;
        ab  = (owner != 0) && m_waitrequest && (TO != 0) && (stalls + 1 == TO);

        if (owner == 1) begin
            e_gnt  = 2'b01;
            e_addr = i_address;
            e_rd   = i_read;
            e_be   = 4'hF;
            if (fin || ab) begin
                e_iw  = 1'b0;
                e_ird = ab ? ERR : m_readdata;
            end
        end else if (owner == 2) begin
            e_gnt  = 2'b10;
            e_addr = d_address;
            e_wr   = d_write;
            e_rd   = d_read && !d_write;
            e_wd   = d_writedata;
            e_be   = d_byteenable;
            if (fin || ab) begin
                e_dw  = 1'b0;
                e_drd = ab ? ERR : m_readdata;
            end
        end

        check("model grant", 32'(grant), 32'(e_gnt));
        check("model i_waitrequest", 32'(i_waitrequest), 32'(e_iw));
        check("model d_waitrequest", 32'(d_waitrequest), 32'(e_dw));
        check("model i_readdata", i_readdata, e_ird);
        check("model d_readdata", d_readdata, e_drd);
        check("model m_address", m_address, e_addr);
        check("model m_read", 32'(m_read), 32'(e_rd));
        check("model m_write", 32'(m_write), 32'(e_wr));
        check("model m_writedata", m_writedata, e_wd);
        check("model m_byteenable", 32'(m_byteenable), 32'(e_be));
        check("model timeout_err", 32'(timeout_err), 32'(err));

        owner_n  = owner;
        last_n   = last_owner;
        stalls_n = stalls;
        if (owner == 0) begin
            stalls_n = 0;
            if (i_read && (d_read || d_write)) owner_n = (last_owner == 2) ? 1 : 2;
            else if (i_read) owner_n = 1;
            else if (d_read || d_write) owner_n = 2;
        end else if (fin || ab) begin
            owner_n  = 0;
            last_n   = owner;
            stalls_n = 0;
        end else begin
            stalls_n = (stalls < 65535) ? stalls + 1 : stalls;
        end
        err_n   = ab ? 1'b1 : (err_clr ? 1'b0 : err);
        seen_iw = e_iw;
        seen_dw = e_dw;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= 0;
            last_owner <= 2;
            stalls     <= 0;
            err        <= 1'b0;
        end else begin
            owner      <= owner_n;
            last_owner <= last_n;
            stalls     <= stalls_n;
            err        <= err_n;
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [1:0] exp_gnt[8];
        bit i_act, d_act, d_rd_k, d_wr_k;
        int bias;

        exp_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

        // Reset with both ports already requesting.
        reset_n = 1'b0;
        i_read = 1'b1; i_address = 32'h40;
        d_write = 1'b1; d_read = 1'b0; d_address = 32'h80;
        d_writedata = 32'h11; d_byteenable = 4'hC;
        m_waitrequest = 1'b0; m_readdata = 32'h55; err_clr = 1'b0;
        tick();
        tick();
        at_neg();
        check("rst grant", 32'(grant), 32'h0);
        check("rst i_waitrequest", 32'(i_waitrequest), 32'h1);
        check("rst d_waitrequest", 32'(d_waitrequest), 32'h1);
        check("rst i_readdata", i_readdata, 32'h0);
        check("rst d_readdata", d_readdata, 32'h0);
        check("rst m_read", 32'(m_read), 32'h0);
        check("rst m_write", 32'(m_write), 32'h0);
        check("rst m_address", m_address, 32'h0);
        check("rst m_writedata", m_writedata, 32'h0);
        check("rst m_byteenable", 32'(m_byteenable), 32'h0);
        check("rst timeout_err", 32'(timeout_err), 32'h0);

        // Alternation with both ports held high from reset release.
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            at_neg();
            check("alt grant", 32'(grant), 32'(exp_gnt[k]));
            check("alt i_waitrequest", 32'(i_waitrequest), (exp_gnt[k] == 2'b01) ? 32'h0 : 32'h1);
            check("alt d_waitrequest", 32'(d_waitrequest), (exp_gnt[k] == 2'b10) ? 32'h0 : 32'h1);
        end
        drain();

        // Single zero-wait instruction read.
        i_read = 1'b1; i_address = 32'h100; m_waitrequest = 1'b0; m_readdata = 32'h12345678;
        at_neg();
        check("iread idle grant", 32'(grant), 32'h0);
        check("iread idle waitreq", 32'(i_waitrequest), 32'h1);
        tick();
        at_neg();
        check("iread grant", 32'(grant), 32'h1);
        check("iread waitreq", 32'(i_waitrequest), 32'h0);
        check("iread readdata", i_readdata, 32'h12345678);
        check("iread m_read", 32'(m_read), 32'h1);
        check("iread m_address", m_address, 32'h100);
        check("iread m_byteenable", 32'(m_byteenable), 32'hF);
        check("iread d_waitrequest", 32'(d_waitrequest), 32'h1);
        tick();
        i_read = 1'b0;
        at_neg();
        check("iread back idle", 32'(grant), 32'h0);

        // Data write with five stall cycles.
        tick();
        d_write = 1'b1; d_address = 32'h2000; d_writedata = 32'hCAFEF00D;
        d_byteenable = 4'b0011; m_waitrequest = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) m_waitrequest = 1'b0;
            at_neg();
            check("dwr grant", 32'(grant), 32'h2);
            check("dwr m_write", 32'(m_write), 32'h1);
            check("dwr m_address", m_address, 32'h2000);
            check("dwr m_writedata", m_writedata, 32'hCAFEF00D);
            check("dwr m_byteenable", 32'(m_byteenable), 32'h3);
            check("dwr d_waitrequest", 32'(d_waitrequest), (k < 6) ? 32'h1 : 32'h0);
            check("dwr i_waitrequest", 32'(i_waitrequest), 32'h1);
        end
        tick();
        d_write = 1'b0;

        // Read and write together: the write wins.
        tick();
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h3000;
        d_writedata = 32'h0BADF00D; d_byteenable = 4'hF; m_waitrequest = 1'b0;
        tick();
        at_neg();
        check("rw grant", 32'(grant), 32'h2);
        check("rw m_write", 32'(m_write), 32'h1);
        check("rw m_read", 32'(m_read), 32'h0);
        check("rw m_writedata", m_writedata, 32'h0BADF00D);
        tick();
        d_read = 1'b0; d_write = 1'b0;

        // Timeout abort while err_clr is held high; the set must win.
        tick();
        d_read = 1'b1; d_address = 32'h4000; m_waitrequest = 1'b1; err_clr = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            at_neg();
            check("to d_waitrequest", 32'(d_waitrequest), (k < 8) ? 32'h1 : 32'h0);
            check("to m_read", 32'(m_read), 32'h1);
            check("to d_readdata", d_readdata, (k < 8) ? 32'h0 : 32'hDEADBEEF);
            check("to err before", 32'(timeout_err), 32'h0);
        end
        tick();
        d_read = 1'b0; err_clr = 1'b0;
        at_neg();
        check("to set beats clear", 32'(timeout_err), 32'h1);
        check("to idle after abort", 32'(grant), 32'h0);
        tick();
        at_neg();
        check("to sticky", 32'(timeout_err), 32'h1);
        tick();
        err_clr = 1'b1;
        at_neg();
        check("to clr pending", 32'(timeout_err), 32'h1);
        tick();
        err_clr = 1'b0;
        at_neg();
        check("to cleared", 32'(timeout_err), 32'h0);

        // Reset in the middle of a stalled data transfer.
        tick();
        d_read = 1'b1; d_address = 32'h5000; m_waitrequest = 1'b1;
        tick();
        tick();
        tick();
        at_neg();
        check("mid grant before rst", 32'(grant), 32'h2);
        #1;
        reset_n = 1'b0;
        i_read = 1'b1; i_address = 32'h600;
        #1;
        check("mid rst grant", 32'(grant), 32'h0);
        check("mid rst d_waitrequest", 32'(d_waitrequest), 32'h1);
        check("mid rst i_waitrequest", 32'(i_waitrequest), 32'h1);
        check("mid rst m_read", 32'(m_read), 32'h0);
        check("mid rst m_address", m_address, 32'h0);
        check("mid rst m_byteenable", 32'(m_byteenable), 32'h0);
        check("mid rst d_readdata", d_readdata, 32'h0);
        tick();
        tick();
        reset_n = 1'b1; m_waitrequest = 1'b0; m_readdata = 32'hA5A5;
        tick();
        at_neg();
        check("mid first grant", 32'(grant), 32'h1);
        check("mid i_waitrequest", 32'(i_waitrequest), 32'h0);
        check("mid i_readdata", i_readdata, 32'hA5A5);
        drain();

        // Random traffic; the model process checks every cycle.
        i_act = 1'b0; d_act = 1'b0; d_rd_k = 1'b0; d_wr_k = 1'b0; bias = 20;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: bias = 15;
                    1: bias = 60;
                    default: bias = 96;
                endcase
            end
            tick();
            if (!seen_iw) i_act = 1'b0;
            if (!seen_dw) d_act = 1'b0;
            if (i_act && $urandom_range(0, 63) == 0) i_act = 1'b0;
            if (d_act && $urandom_range(0, 63) == 0) d_act = 1'b0;
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1'b1;
                i_address = $urandom;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1'b1;
                case ($urandom_range(0, 4))
                    0, 1: begin d_rd_k = 1'b1; d_wr_k = 1'b0; end
                    2, 3: begin d_rd_k = 1'b0; d_wr_k = 1'b1; end
                    default: begin d_rd_k = 1'b1; d_wr_k = 1'b1; end
                endcase
                d_address    = $urandom;
                d_writedata  = $urandom;
                d_byteenable = 4'($urandom_range(0, 15));
            end
            i_read        = i_act;
            d_read        = d_act && d_rd_k;
            d_write       = d_act && d_wr_k;
            m_waitrequest = ($urandom_range(0, 99) < bias);
            m_readdata    = $urandom;
            err_clr       = ($urandom_range(0, 19) == 0);
        end
        drain();
        at_neg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
